// File: rtl/adc_agc_ctrl.sv
// ============================================================================
//  Module      : adc_agc_ctrl
//  Description : Peak-detecting automatic gain control for a 12-bit ADC front
//                end, with settle blanking and a manual gain override.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module adc_agc_ctrl #(
  parameter int unsigned WIN_LEN    = 1024,
  parameter int unsigned SETTLE_CYC = 64,
  parameter int unsigned HI_THR     = 1900,
  parameter int unsigned LO_THR     = 500,
  parameter logic [3:0]  GAIN_INIT  = 4'd8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [11:0] sample,
  input  logic        sample_vld,
  input  logic        man_mode,
  input  logic [3:0]  man_gain,
  output logic [3:0]  gain,
  output logic        gain_upd,
  output logic        data_ok,
  output logic [11:0] peak,
  output logic        peak_vld
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MEASURE = 2'd1,
    S_DECIDE  = 2'd2,
    S_SETTLE  = 2'd3
  } state_t;

  localparam logic [15:0] c_win_last    = 16'(WIN_LEN - 1);
  localparam logic [15:0] c_settle_last = 16'(SETTLE_CYC - 1);
  localparam logic [31:0] c_hi_thr      = 32'(HI_THR);
  localparam logic [31:0] c_lo_thr      = 32'(LO_THR);

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [10:0] r_max;

  logic [10:0] w_neg;
  logic [10:0] w_mag;
  logic [10:0] w_max_nxt;
  logic [31:0] w_peak_ext;
  logic        w_gain_dn;
  logic        w_gain_up;

  // Negation of the low 11 bits is exact for every negative code except
  // -2048, whose magnitude does not fit and is clamped to 2047.
  always_comb begin
    w_neg = ~sample[10:0] + 11'd1;
    if (!sample[11])
      w_mag = sample[10:0];
    else if (sample[10:0] == 11'd0)
      w_mag = 11'h7FF;
    else
      w_mag = w_neg;
  end

  assign w_max_nxt  = (w_mag > r_max) ? w_mag : r_max;
  assign w_peak_ext = {20'd0, peak};
  assign w_gain_dn  = (w_peak_ext >= c_hi_thr) && (gain != 4'd0);
  assign w_gain_up  = (w_peak_ext <  c_hi_thr) && (w_peak_ext < c_lo_thr) && (gain != 4'd15);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 16'd0;
      r_max    <= 11'd0;
      gain     <= GAIN_INIT;
      gain_upd <= 1'b0;
      data_ok  <= 1'b0;
      peak     <= 12'd0;
      peak_vld <= 1'b0;
    end else begin
      gain_upd <= 1'b0;
      peak_vld <= 1'b0;

      if (man_mode) begin
        // Manual override wins over enable; any partial window is dropped.
        r_state  <= S_IDLE;
        r_cnt    <= 16'd0;
        r_max    <= 11'd0;
        data_ok  <= 1'b0;
        gain     <= man_gain;
        gain_upd <= (man_gain != gain);
      end else if (!en) begin
        r_state <= S_IDLE;
        r_cnt   <= 16'd0;
        r_max   <= 11'd0;
        data_ok <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_MEASURE;
            r_cnt   <= 16'd0;
            r_max   <= 11'd0;
          end

          S_MEASURE: begin
            if (sample_vld) begin
              if (r_cnt == c_win_last) begin
                peak     <= {1'b0, w_max_nxt};
                peak_vld <= 1'b1;
                r_state  <= S_DECIDE;
                r_cnt    <= 16'd0;
                r_max    <= 11'd0;
              end else begin
                r_cnt <= r_cnt + 16'd1;
                r_max <= w_max_nxt;
              end
            end
          end

          S_DECIDE: begin
            r_cnt <= 16'd0;
            r_max <= 11'd0;
            if (w_gain_dn || w_gain_up) begin
              gain     <= w_gain_dn ? (gain - 4'd1) : (gain + 4'd1);
              gain_upd <= 1'b1;
              data_ok  <= 1'b0;
              r_state  <= S_SETTLE;
            end else begin
              data_ok <= 1'b1;
              r_state <= S_MEASURE;
            end
          end

          S_SETTLE: begin
            // Blanking is timed in clock cycles; sample_vld plays no part.
            if (r_cnt == c_settle_last) begin
              r_state <= S_MEASURE;
              r_cnt   <= 16'd0;
              r_max   <= 11'd0;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end

          default: begin
            r_state <= S_IDLE;
            r_cnt   <= 16'd0;
            r_max   <= 11'd0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_adc_agc_ctrl.sv
// ============================================================================
//  Module      : tb_adc_agc_ctrl
//  Description : Scoreboard bench for adc_agc_ctrl with a window-level model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_adc_agc_ctrl;

  localparam int WIN = 16;
  localparam int SET = 64;
  localparam int HI  = 1900;
  localparam int LO  = 500;
  localparam int GI  = 8;

  localparam int SIG_GAIN = 0;
  localparam int SIG_OK   = 1;
  localparam int SIG_PEAK = 2;
  localparam int SIG_PVLD = 3;
  localparam int SIG_UPD  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [11:0] sample = 12'd0;
  logic        sample_vld = 1'b0;
  logic        man_mode = 1'b0;
  logic [3:0]  man_gain = 4'd0;
  logic [3:0]  gain;
  logic        gain_upd;
  logic        data_ok;
  logic [11:0] peak;
  logic        peak_vld;

  adc_agc_ctrl #(
    .WIN_LEN   (WIN),
    .SETTLE_CYC(SET),
    .HI_THR    (HI),
    .LO_THR    (LO),
    .GAIN_INIT (4'(GI))
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .sample    (sample),
    .sample_vld(sample_vld),
    .man_mode  (man_mode),
    .man_gain  (man_gain),
    .gain      (gain),
    .gain_upd  (gain_upd),
    .data_ok   (data_ok),
    .peak      (peak),
    .peak_vld  (peak_vld)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    sig;
    int    exp;
  } chk_t;

  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_peak_q[$];
  int   exp_gain_q[$];
  chk_t chk_q[$];
  int   win_q[$];
  int   mdl_gain = GI;
  bit   done = 1'b0;
  bit   fin = 1'b0;

  // ---------------- reference model (window level) ----------------
  function automatic int mag_of(int s);
    int m;
    m = (s < 0) ? -s : s;
    return (m > 2047) ? 2047 : m;
  endfunction

  function automatic int next_gain(int pk, int g);
    if (pk >= HI && g > 0)  return g - 1;
    if (pk < LO && g < 15)  return g + 1;
    return g;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  function automatic int sig_val(int k);
    case (k)
      SIG_GAIN: return int'(gain);
      SIG_OK:   return int'(data_ok);
      SIG_PEAK: return int'(peak);
      SIG_PVLD: return int'(peak_vld);
      default:  return int'(gain_upd);
    endcase
  endfunction

  task automatic check(string name, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    chk_t c;
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      check(c.name, sig_val(c.sig), c.exp);
    end
    if (!rst) begin
      if (peak_vld) begin
        if (exp_peak_q.size() == 0) check("unexpected_peak_vld", int'(peak), -1);
        else                        check("peak", int'(peak), exp_peak_q.pop_front());
      end
      if (gain_upd) begin
        if (exp_gain_q.size() == 0) check("unexpected_gain_upd", int'(gain), -1);
        else                        check("gain_upd_value", int'(gain), exp_gain_q.pop_front());
      end
    end
    if (done && !fin) begin
      check("peak_queue_left", exp_peak_q.size(), 0);
      check("gain_queue_left", exp_gain_q.size(), 0);
      fin = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic expect_now(string n, int k, int e);
    chk_t c;
    c.name = n;
    c.sig  = k;
    c.exp  = e;
    chk_q.push_back(c);
  endtask

  task automatic drive(logic v, int s);
    @(posedge clk);
    #1;
    sample_vld = v;
    sample     = 12'(s);
  endtask

  // Full-scale valid samples during non-measuring cycles expose miscounting.
  task automatic garbage();
    drive(1'b1, 2047);
  endtask

  task automatic start();
    @(posedge clk);
    #1;
    en         = 1'b1;
    man_mode   = 1'b0;
    sample_vld = 1'b1;
    sample     = 12'h7FF;
  endtask

  task automatic fill_const(int v);
    win_q.delete();
    repeat (WIN) win_q.push_back(v);
  endtask

  task automatic run_window(int gap_mode, bit stop_in_settle);
    int pk;
    int m;
    int ng;
    bit chg;
    pk = 0;
    foreach (win_q[i]) begin
      m = mag_of(win_q[i]);
      if (m > pk) pk = m;
      if (gap_mode == 1) drive(1'b0, 2047);
      else if (gap_mode == 2) while ($urandom_range(99) < 30) drive(1'b0, 2047);
      drive(1'b1, win_q[i]);
    end
    exp_peak_q.push_back(pk);
    ng  = next_gain(pk, mdl_gain);
    chg = (ng != mdl_gain);
    if (chg) exp_gain_q.push_back(ng);
    mdl_gain = ng;
    garbage();
    @(posedge clk);
    #1;
    expect_now("data_ok_after_decide", SIG_OK, chg ? 0 : 1);
    expect_now("gain_after_decide", SIG_GAIN, mdl_gain);
    if (chg) begin
      sample_vld = 1'b1;
      sample     = 12'h7FF;
      if (stop_in_settle) begin
        repeat (10) garbage();
      end else begin
        repeat (SET - 1) begin
          garbage();
          expect_now("data_ok_in_settle", SIG_OK, 0);
        end
      end
    end else begin
      sample_vld = 1'b0;
    end
  endtask

  task automatic reset_now();
    @(posedge clk);
    #3;
    rst = 1'b1;
    expect_now("rst_gain", SIG_GAIN, GI);
    expect_now("rst_data_ok", SIG_OK, 0);
    expect_now("rst_peak", SIG_PEAK, 0);
    expect_now("rst_peak_vld", SIG_PVLD, 0);
    expect_now("rst_gain_upd", SIG_UPD, 0);
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    en       = 1'b0;
    mdl_gain = GI;
  endtask

  initial begin
    int lim;
    int pos;
    int lims[4] = '{300, 700, 1900, 2047};

    @(posedge clk);
    #1;
    expect_now("reset_gain", SIG_GAIN, GI);
    expect_now("reset_data_ok", SIG_OK, 0);
    expect_now("reset_peak", SIG_PEAK, 0);
    expect_now("reset_peak_vld", SIG_PVLD, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Loud constant input: 8 -> 7, blanking, then a second window mid-SETTLE reset.
    start();
    fill_const(2000);
    run_window(0, 1'b0);
    fill_const(2000);
    run_window(2, 1'b1);
    reset_now();

    // Quiet input ramps gain to 15 then holds.
    start();
    fill_const(-100);
    repeat (9) run_window(2, 1'b0);

    // Single -2048 sample in a silent window.
    win_q.delete();
    repeat (WIN) win_q.push_back(0);
    pos = $urandom_range(WIN - 1);
    win_q[pos] = -2048;
    run_window(2, 1'b0);

    // Mid-band level with alternating qualifier.
    fill_const(1000);
    run_window(1, 1'b0);

    // Enable drop mid-window discards the partial window.
    repeat (5) drive(1'b1, 2000);
    @(posedge clk);
    #1;
    en         = 1'b0;
    sample_vld = 1'b1;
    sample     = 12'h7FF;
    repeat (2) garbage();
    expect_now("en_off_data_ok", SIG_OK, 0);
    expect_now("en_off_gain_hold", SIG_GAIN, mdl_gain);
    start();
    fill_const(800);
    run_window(2, 1'b0);

    // Threshold boundaries.
    fill_const(1900);  run_window(2, 1'b0);
    fill_const(500);   run_window(2, 1'b0);
    fill_const(-500);  run_window(0, 1'b0);
    fill_const(499);   run_window(2, 1'b0);
    fill_const(-1900); run_window(2, 1'b0);

    // Manual override during MEASURE.
    repeat (4) drive(1'b1, 2000);
    @(posedge clk);
    #1;
    man_mode   = 1'b1;
    man_gain   = 4'd3;
    sample_vld = 1'b1;
    sample     = 12'h7FF;
    if (mdl_gain != 3) exp_gain_q.push_back(3);
    mdl_gain = 3;
    @(posedge clk);
    #1;
    expect_now("man_gain_3", SIG_GAIN, 3);
    expect_now("man_data_ok", SIG_OK, 0);
    expect_now("man_gain_upd", SIG_UPD, 1);
    repeat (4) garbage();
    @(posedge clk);
    #1;
    man_gain = 4'd5;
    exp_gain_q.push_back(5);
    mdl_gain = 5;
    @(posedge clk);
    #1;
    expect_now("man_gain_5", SIG_GAIN, 5);
    start();
    fill_const(1000);
    run_window(2, 1'b0);

    // Randomized windows.
    repeat (12) begin
      lim = lims[$urandom_range(3)];
      win_q.delete();
      repeat (WIN) win_q.push_back(int'($urandom_range(2 * lim)) - lim);
      if ($urandom_range(7) == 0) win_q[$urandom_range(WIN - 1)] = -2048;
      run_window(2, 1'b0);
    end

    repeat (3) @(posedge clk);
    done = 1'b1;
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/adc_agc_ctrl.md
ADC_AGC_CTRL -- requirements
Module: adc_agc_ctrl

Interface
- REQ-001: The block SHALL have one clock, clk, and one reset, rst, which is asynchronous and active-high.
- REQ-002: Parameter WIN_LEN SHALL default to 1024; it sets the number of valid samples per peak-measurement window (range 2..65535).
- REQ-003: Parameter SETTLE_CYC SHALL default to 64; it sets the clk cycles of blanking after a gain change (range 1..65535).
- REQ-004: Parameter HI_THR SHALL default to 1900; a peak at or above it reduces gain.
- REQ-005: Parameter LO_THR SHALL default to 500; a peak below it raises gain; LO_THR < HI_THR is required.
- REQ-006: Parameter GAIN_INIT SHALL default to 4'd8; it is the gain code after reset.
- REQ-007: clk  in  1  system/ADC sample clock.
- REQ-008: rst  in  1  asynchronous active-high reset.
- REQ-009: en  in  1  AGC enable.
- REQ-010: sample  in  12  two's-complement ADC sample (MSB already inverted from offset binary).
- REQ-011: sample_vld  in  1  sample qualifier.
- REQ-012: man_mode  in  1  1 = manual gain, AGC suspended.
- REQ-013: man_gain  in  4  manual gain code.
- REQ-014: gain  out  4  gain code driven to the amplifier bits.
- REQ-015: gain_upd  out  1  one-cycle pulse, asserted in the same cycle that gain changes value.
- REQ-016: data_ok  out  1  level; 1 = gain is stable and the last window was within thresholds.
- REQ-017: peak  out  12  unsigned peak magnitude of the last completed window.
- REQ-018: peak_vld  out  1  one-cycle pulse when peak updates.

Function
- REQ-019: The FSM SHALL have exactly four states: IDLE, MEASURE, DECIDE, SETTLE.
- REQ-020: Magnitude SHALL be mag = |sample|, with -2048 saturated to 2047, so mag always fits in 11 bits unsigned.
- REQ-021: IDLE: with en=1 and man_mode=0, the FSM SHALL enter MEASURE on the next cycle and clear the sample counter and running maximum.
- REQ-022: MEASURE: on each sample_vld cycle the block SHALL set running max = max(running max, mag) and increment the counter; cycles without sample_vld are ignored.
- REQ-023: On the WIN_LEN-th valid sample, the block SHALL load peak with the final max (including that sample), pulse peak_vld for 1 cycle, and enter DECIDE on the next cycle.
- REQ-024: DECIDE lasts exactly 1 cycle; the registered gain decision SHALL become visible on the cycle after DECIDE:
  - if peak >= HI_THR and gain > 0: gain-1;
  - else if peak < LO_THR and gain < 15: gain+1;
  - else: gain is unchanged.
- REQ-025: On a gain change, gain_upd SHALL pulse, data_ok SHALL go to 0, and the FSM SHALL enter SETTLE.
- REQ-026: With no gain change (including when saturated at 0 or 15), data_ok SHALL go to 1 and the FSM SHALL return to MEASURE with counter and max cleared.
- REQ-027: SETTLE SHALL count SETTLE_CYC clk cycles regardless of sample_vld, then enter MEASURE with counter and max cleared; data_ok stays 0 throughout.
- REQ-028: If en=0 in any state, the FSM SHALL enter IDLE next cycle, data_ok SHALL go to 0, gain SHALL hold, and any partial window is discarded.
- REQ-029: man_mode=1 SHALL take priority over en: the FSM is forced to IDLE, data_ok=0, and gain follows man_gain with 1-cycle latency.
- REQ-030: In manual mode, gain_upd SHALL pulse only when the loaded value differs from the previous gain.
- REQ-031: When man_mode returns to 0 with en=1, the FSM SHALL start from IDLE using the current gain.
- REQ-032: A peak exactly equal to HI_THR SHALL reduce gain; a peak exactly equal to LO_THR SHALL leave gain unchanged.
- REQ-033: The counter SHALL be 16 bits and SHALL never wrap within a window.

Reset
- REQ-034: While rst=1, outputs SHALL be: state=IDLE, gain=GAIN_INIT, gain_upd=0, data_ok=0, peak=0, peak_vld=0, and counters=0, taking effect immediately without waiting for clk.
- REQ-035: Reset asserted mid-window or mid-SETTLE SHALL abort the operation; after release the block SHALL behave as if freshly started.

Verification
- REQ-036: The bench SHALL cover: WIN_LEN=16, constant sample=12'h7D0 (2000), gain=8 -> peak_vld with peak=2000, then gain=7 with a gain_upd pulse, data_ok=0, 64 blanking cycles, and a new window.
- REQ-037: The bench SHALL cover: constant sample=-100 -> gain steps 8,9,...,15, then holds at 15 with data_ok=1 and no further gain_upd.
- REQ-038: The bench SHALL cover: a single sample=12'h800 in an otherwise quiet window -> peak=2047 and gain decrements.
- REQ-039: The bench SHALL cover: sample=1000 with toggling sample_vld -> window completes after exactly 16 valid samples, gain is unchanged, and data_ok=1.
- REQ-040: The bench SHALL cover: man_mode=1 with man_gain=3 during MEASURE -> gain=3 next cycle, one gain_upd pulse, FSM in IDLE, data_ok=0.
- REQ-041: The bench SHALL cover: rst pulsed mid-SETTLE -> gain=8, all outputs 0, immediately and asynchronously.
